proc_req_sequencer: RTL and testbench
=====================================

Name: proc_req_sequencer

Overview:
Sits directly upstream of the address segregator in each core's L1 path. Buffers processor read/write requests in a small FIFO and presents one request at a time as cmd_rd/cmd_wr/address. It holds that request stable until the cache controller signals completion, then returns a one-cycle done pulse and read data to the processor. A timeout guards against a hung controller.

Parameters:
ADDR_WID, 32, processor address width
DATA_WID, 32, data width
FIFO_DEPTH, 2, request buffer entries (power of 2, >=2)
TIMEOUT_CYC, 255, max cycles in WAIT before abort (>=1)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
cpu_rd  input  1  processor read request
cpu_wr  input  1  processor write request
cpu_addr  input  ADDR_WID  request address
cpu_wdata  input  DATA_WID  write data
cpu_ready  output  1  FIFO can accept this cycle
cpu_done  output  1  one-cycle completion pulse
cpu_rdata  output  DATA_WID  read data, valid with cpu_done
cmd_rd  output  1  to segregator/controller: read in progress
cmd_wr  output  1  to segregator/controller: write in progress
address  output  ADDR_WID  current request address
wdata  output  DATA_WID  current write data
ctrl_done  input  1  controller finished current access
ctrl_rdata  input  DATA_WID  controller read data, valid with ctrl_done
err_timeout  output  1  one-cycle pulse on timeout abort
err_illegal  output  1  one-cycle pulse when cpu_rd and cpu_wr both high
busy  output  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0 except cpu_ready=1. FIFO is empty, FSM is IDLE, and the timeout counter is 0.
- Reset mid-operation: any in-flight request and all buffered requests are discarded. No cpu_done is produced for them.
- Push: occurs when cpu_ready && (cpu_rd ^ cpu_wr). The entry stores {is_wr, addr, wdata}.
- Illegal request: cpu_rd && cpu_wr is never pushed. err_illegal pulses the next cycle, regardless of cpu_ready.
- cpu_ready is the registered "count < FIFO_DEPTH".
  - There is no same-cycle bypass: at full, a pop in the same cycle does not raise cpu_ready until the next cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE -> ISSUE when FIFO is non-empty. The head is popped and loaded into the output registers.
  - ISSUE -> WAIT after 1 cycle. cmd_rd/cmd_wr/address/wdata are driven from ISSUE through WAIT inclusive.
  - WAIT -> RESP when ctrl_done is sampled high. ctrl_rdata is captured into cpu_rdata.
  - WAIT -> RESP also when the timeout counter reaches TIMEOUT_CYC. In that case err_timeout pulses, cpu_rdata=0, and cpu_done still pulses.
  - RESP -> IDLE after 1 cycle. cpu_done=1 only in RESP. cmd_* and address/wdata return to 0 in RESP.
- ctrl_done outside WAIT is ignored.
- Latency: a push in cycle N to an empty, idle block gives IDLE in N+1, cmd_* high from N+2. With ctrl_done in cycle M, cpu_done is high in M+1.
- Minimum request-to-request spacing is 4 cycles.
- cpu_rdata is held until the next RESP. It is 0 for writes.
- Outputs are in-order; one request is outstanding at a time.
- Timeout counter: cleared on entering WAIT, increments each WAIT cycle. Its width is $clog2(TIMEOUT_CYC+1).
- FIFO pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH+1).
- Push and pop in the same cycle is legal whenever not full: count is unchanged and both pointers advance.

Decomposition:
- Package proc_req_pkg contains:
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} req_state_e;
  - typedef struct packed {is_wr, addr, wdata} proc_req_t;
- One sub-module, req_fifo: a parameterised synchronous FIFO with push/pop/full/empty/count and asynchronous active-low reset.

Test Plan:
- Single read: push rd addr 0x0001_2344, ctrl_done 3 cycles after cmd_rd with rdata 0xDEADBEEF.
  - cmd_rd high from N+2 with address 0x0001_2344.
  - cpu_done one cycle after ctrl_done with cpu_rdata 0xDEADBEEF.
- Back-to-back: 3 writes pushed on consecutive cycles, FIFO_DEPTH=2, controller stalled.
  - cpu_ready drops after 2 buffered (plus 1 in flight).
  - Writes complete in order with 3 cpu_done pulses, each wdata matching its push.
- Illegal: cpu_rd=cpu_wr=1 with addr 0xFFFF_FFFC.
  - err_illegal pulses for 1 cycle, nothing is pushed, and busy stays 0.
- Timeout: TIMEOUT_CYC=8, push rd, never assert ctrl_done.
  - err_timeout and cpu_done pulse together, cpu_rdata=0.
  - FSM returns to IDLE and the next queued request issues.
- Reset mid-WAIT: 2 requests queued, assert rst_n low for 1 cycle during WAIT.
  - All outputs take reset values asynchronously.
  - No cpu_done follows and busy=0 after release.
- Stray ctrl_done: assert ctrl_done in IDLE and ISSUE.
  - No cpu_done and no state change.

Source files
------------

// File: rtl/proc_req_pkg.sv
// Shared types for the processor request sequencer: FSM state encoding and
// the buffered request entry.
package proc_req_pkg;

    localparam int unsigned REQ_ADDR_WID = 32;
    localparam int unsigned REQ_DATA_WID = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } req_state_e;

    typedef struct packed {
        logic                    is_wr;
        logic [REQ_ADDR_WID-1:0] addr;
        logic [REQ_DATA_WID-1:0] wdata;
    } proc_req_t;

    function automatic logic is_request(input logic rd, input logic wr);
        return rd ^ wr;
    endfunction

    function automatic logic is_illegal(input logic rd, input logic wr);
        return rd & wr;
    endfunction

endpackage

// File: rtl/req_fifo.sv
// Synchronous request FIFO; pointers wrap naturally since DEPTH is a power of 2.
module req_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == CNT_W'(0));
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            r_wr_ptr <= w_push_ok ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
            r_rd_ptr <= w_pop_ok  ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
            r_count  <= w_count_nxt;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/proc_req_sequencer.sv
// Buffers processor requests and presents them one at a time to the cache
// controller, returning a done pulse (with read data) or a timeout abort.
module proc_req_sequencer
    import proc_req_pkg::*;
#(
    parameter int unsigned ADDR_WID    = 32,
    parameter int unsigned DATA_WID    = 32,
    parameter int unsigned FIFO_DEPTH  = 2,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_rd,
    input  logic                cpu_wr,
    input  logic [ADDR_WID-1:0] cpu_addr,
    input  logic [DATA_WID-1:0] cpu_wdata,
    output logic                cpu_ready,
    output logic                cpu_done,
    output logic [DATA_WID-1:0] cpu_rdata,
    output logic                cmd_rd,
    output logic                cmd_wr,
    output logic [ADDR_WID-1:0] address,
    output logic [DATA_WID-1:0] wdata,
    input  logic                ctrl_done,
    input  logic [DATA_WID-1:0] ctrl_rdata,
    output logic                err_timeout,
    output logic                err_illegal,
    output logic                busy
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned REQ_W = $bits(proc_req_t);

    req_state_e          r_state;
    req_state_e          w_state_nxt;
    proc_req_t           w_req_in;
    proc_req_t           w_head;
    logic [REQ_W-1:0]    w_head_bits;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_to_hit;
    logic [CNT_W-1:0]    w_count;
    logic [CNT_W-1:0]    w_count_nxt;
    logic [TO_W-1:0]     r_tcnt;

    logic                r_cpu_ready,   w_cpu_ready_nxt;
    logic                r_cpu_done,    w_cpu_done_nxt;
    logic [DATA_WID-1:0] r_cpu_rdata,   w_cpu_rdata_nxt;
    logic                r_cmd_rd,      w_cmd_rd_nxt;
    logic                r_cmd_wr,      w_cmd_wr_nxt;
    logic [ADDR_WID-1:0] r_address,     w_address_nxt;
    logic [DATA_WID-1:0] r_wdata,       w_wdata_nxt;
    logic                r_err_timeout, w_err_timeout_nxt;
    logic                r_err_illegal, w_err_illegal_nxt;
    logic                r_busy,        w_busy_nxt;

    assign w_req_in.is_wr = cpu_wr;
    assign w_req_in.addr  = REQ_ADDR_WID'(cpu_addr);
    assign w_req_in.wdata = REQ_DATA_WID'(cpu_wdata);
    assign w_head         = proc_req_t'(w_head_bits);

    assign w_push   = r_cpu_ready && !w_full && is_request(cpu_rd, cpu_wr);
    assign w_pop    = (r_state == IDLE) && !w_empty;
    assign w_to_hit = (r_state == WAIT) && !ctrl_done && (r_tcnt == TO_W'(TIMEOUT_CYC));

    req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_req_in),
        .o_rdata (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Occupancy the FIFO will hold next cycle; cpu_ready and busy register it.
    always_comb begin
        w_count_nxt = w_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = w_count + CNT_W'(1);
            2'b01:   w_count_nxt = w_count - CNT_W'(1);
            default: w_count_nxt = w_count;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state; ctrl_done wins over a coincident timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = ISSUE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ISSUE: w_state_nxt = WAIT;
            WAIT: begin
                if (ctrl_done || w_to_hit) begin
                    w_state_nxt = RESP;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs: next values for every registered output.
    always_comb begin
        w_cmd_rd_nxt      = r_cmd_rd;
        w_cmd_wr_nxt      = r_cmd_wr;
        w_address_nxt     = r_address;
        w_wdata_nxt       = r_wdata;
        w_cpu_rdata_nxt   = r_cpu_rdata;
        w_cpu_done_nxt    = 1'b0;
        w_err_timeout_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_cmd_rd_nxt  = !w_head.is_wr;
                    w_cmd_wr_nxt  = w_head.is_wr;
                    w_address_nxt = ADDR_WID'(w_head.addr);
                    w_wdata_nxt   = w_head.is_wr ? DATA_WID'(w_head.wdata) : {DATA_WID{1'b0}};
                end else begin
                    w_cmd_rd_nxt  = 1'b0;
                    w_cmd_wr_nxt  = 1'b0;
                    w_address_nxt = {ADDR_WID{1'b0}};
                    w_wdata_nxt   = {DATA_WID{1'b0}};
                end
            end
            ISSUE: begin
                w_cpu_done_nxt = 1'b0;
            end
            WAIT: begin
                if (ctrl_done || w_to_hit) begin
                    w_cmd_rd_nxt      = 1'b0;
                    w_cmd_wr_nxt      = 1'b0;
                    w_address_nxt     = {ADDR_WID{1'b0}};
                    w_wdata_nxt       = {DATA_WID{1'b0}};
                    w_cpu_done_nxt    = 1'b1;
                    w_err_timeout_nxt = w_to_hit;
                    w_cpu_rdata_nxt   = (ctrl_done && r_cmd_rd) ? ctrl_rdata : {DATA_WID{1'b0}};
                end else begin
                    w_cpu_done_nxt    = 1'b0;
                end
            end
            RESP: begin
                w_cpu_done_nxt = 1'b0;
            end
            default: begin
                w_cmd_rd_nxt    = 1'b0;
                w_cmd_wr_nxt    = 1'b0;
                w_address_nxt   = {ADDR_WID{1'b0}};
                w_wdata_nxt     = {DATA_WID{1'b0}};
                w_cpu_rdata_nxt = {DATA_WID{1'b0}};
            end
        endcase
        w_cpu_ready_nxt   = (w_count_nxt < CNT_W'(FIFO_DEPTH));
        w_busy_nxt        = (w_count_nxt != CNT_W'(0)) || (w_state_nxt != IDLE);
        w_err_illegal_nxt = is_illegal(cpu_rd, cpu_wr);
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_ready   <= 1'b1;
            r_cpu_done    <= 1'b0;
            r_cpu_rdata   <= {DATA_WID{1'b0}};
            r_cmd_rd      <= 1'b0;
            r_cmd_wr      <= 1'b0;
            r_address     <= {ADDR_WID{1'b0}};
            r_wdata       <= {DATA_WID{1'b0}};
            r_err_timeout <= 1'b0;
            r_err_illegal <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_cpu_ready   <= w_cpu_ready_nxt;
            r_cpu_done    <= w_cpu_done_nxt;
            r_cpu_rdata   <= w_cpu_rdata_nxt;
            r_cmd_rd      <= w_cmd_rd_nxt;
            r_cmd_wr      <= w_cmd_wr_nxt;
            r_address     <= w_address_nxt;
            r_wdata       <= w_wdata_nxt;
            r_err_timeout <= w_err_timeout_nxt;
            r_err_illegal <= w_err_illegal_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    // Timeout counter: zeroed in ISSUE so it starts at 0 on the first WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= {TO_W{1'b0}};
        end else begin
            case (r_state)
                ISSUE: r_tcnt <= {TO_W{1'b0}};
                WAIT: begin
                    if (!w_to_hit) begin
                        r_tcnt <= r_tcnt + TO_W'(1);
                    end else begin
                        r_tcnt <= r_tcnt;
                    end
                end
                default: r_tcnt <= {TO_W{1'b0}};
            endcase
        end
    end

    assign cpu_ready   = r_cpu_ready;
    assign cpu_done    = r_cpu_done;
    assign cpu_rdata   = r_cpu_rdata;
    assign cmd_rd      = r_cmd_rd;
    assign cmd_wr      = r_cmd_wr;
    assign address     = r_address;
    assign wdata       = r_wdata;
    assign err_timeout = r_err_timeout;
    assign err_illegal = r_err_illegal;
    assign busy        = r_busy;

endmodule

// File: tb/tb_proc_req_sequencer.sv
// Scoreboard bench: stimulus queues expected responses, a controller model
// answers commands, and a monitor checks every cpu_done in order.
module tb_proc_req_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        cmd_rd;
    logic        cmd_wr;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        ctrl_done;
    logic [31:0] ctrl_rdata;
    logic        err_timeout;
    logic        err_illegal;
    logic        busy;
    logic        mdl_done;
    logic        stray_done;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        int          dly;
        logic [31:0] rd;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        to;
    } resp_t;

    req_t  ctrl_q[$];
    resp_t exp_q[$];
    int    cyc           = 0;
    int    n_cmp         = 0;
    int    n_bad         = 0;
    int    last_done_cyc = -100;
    int    push_cyc      = 0;

    assign ctrl_done = mdl_done | stray_done;

    proc_req_sequencer #(
        .ADDR_WID    (32),
        .DATA_WID    (32),
        .FIFO_DEPTH  (2),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ready   (cpu_ready),
        .cpu_done    (cpu_done),
        .cpu_rdata   (cpu_rdata),
        .cmd_rd      (cmd_rd),
        .cmd_wr      (cmd_wr),
        .address     (address),
        .wdata       (wdata),
        .ctrl_done   (ctrl_done),
        .ctrl_rdata  (ctrl_rdata),
        .err_timeout (err_timeout),
        .err_illegal (err_illegal),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drive one request, wait (bounded) for cpu_ready, queue model and expectation.
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int dly, input logic [31:0] rd);
        int    tries;
        req_t  r;
        resp_t e;
        tries     = 0;
        cpu_rd    = !w;
        cpu_wr    = w;
        cpu_addr  = a;
        cpu_wdata = d;
        while (cpu_ready !== 1'b1 && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        if (cpu_ready !== 1'b1) begin
            chk("send_ready_wait", 32'(cpu_ready), 32'd1);
        end else begin
            r.w = w; r.a = a; r.d = d; r.dly = dly; r.rd = rd;
            e.to    = (dly < 0);
            e.rdata = (e.to || w) ? 32'h0 : rd;
            ctrl_q.push_back(r);
            exp_q.push_back(e);
            push_cyc = cyc;
        end
        @(negedge clk);
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_outstanding", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Cache controller model: checks each new command, then answers after dly cycles.
    initial begin : ctrl_model
        logic prev;
        req_t r;
        int   t;
        prev       = 1'b0;
        mdl_done   = 1'b0;
        ctrl_rdata = 32'h5A5A_5A5A;
        forever begin
            @(negedge clk);
            if ((cmd_rd === 1'b1 || cmd_wr === 1'b1) && !prev) begin
                if (ctrl_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_cmd: address %h issued, none expected", address);
                end else begin
                    r = ctrl_q.pop_front();
                    chk("cmd_wr", 32'(cmd_wr), 32'(r.w));
                    chk("cmd_rd", 32'(cmd_rd), 32'(!r.w));
                    chk("cmd_address", address, r.a);
                    chk("cmd_wdata", wdata, r.w ? r.d : 32'h0);
                    if (r.dly > 0) begin
                        repeat (r.dly) @(negedge clk);
                        mdl_done      = 1'b1;
                        ctrl_rdata    = r.rd;
                        last_done_cyc = cyc;
                        @(negedge clk);
                        mdl_done   = 1'b0;
                        ctrl_rdata = 32'h5A5A_5A5A;
                    end else begin
                        t = 0;
                        while ((cmd_rd === 1'b1 || cmd_wr === 1'b1) && t < 40) begin
                            @(negedge clk);
                            t++;
                        end
                    end
                end
            end
            prev = (cmd_rd === 1'b1) || (cmd_wr === 1'b1);
        end
    end

    // Response monitor: pops one expectation per cpu_done.
    initial begin : monitor
        resp_t e;
        forever begin
            @(negedge clk);
            if (cpu_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: cpu_rdata %h with nothing outstanding", cpu_rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_rdata", cpu_rdata, e.rdata);
                    chk("done_timeout", 32'(err_timeout), 32'(e.to));
                    if (!e.to) begin
                        chk("done_latency", 32'(cyc), 32'(last_done_cyc + 1));
                    end
                end
            end else if (err_timeout === 1'b1) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stray_timeout: err_timeout=1 without cpu_done");
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: bench did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst_n      = 1'b0;
        cpu_rd     = 1'b0;
        cpu_wr     = 1'b0;
        cpu_addr   = 32'h0;
        cpu_wdata  = 32'h0;
        stray_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cpu_ready", 32'(cpu_ready), 32'd1);
        chk("rst_cpu_done", 32'(cpu_done), 32'd0);
        chk("rst_cmd", 32'({cmd_rd, cmd_wr}), 32'd0);
        chk("rst_address", address, 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_errs", 32'({err_timeout, err_illegal}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Stray ctrl_done while IDLE.
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        chk("stray_idle_busy", 32'(busy), 32'd0);
        chk("stray_idle_cmd", 32'(cmd_rd), 32'd0);
        @(negedge clk);
        chk("stray_idle_done", 32'(cpu_done), 32'd0);

        // Single read with latency checks.
        send(1'b0, 32'h0001_2344, 32'h0, 3, 32'hDEAD_BEEF);
        chk("rd_cmd_n1", 32'(cmd_rd), 32'd0);
        chk("rd_busy_n1", 32'(busy), 32'd1);
        @(negedge clk);
        chk("rd_cmd_n2", 32'(cmd_rd), 32'd1);
        chk("rd_addr_n2", address, 32'h0001_2344);
        chk("rd_cyc_n2", 32'(cyc), 32'(push_cyc + 2));
        drain();
        chk("rd_rdata_held", cpu_rdata, 32'hDEAD_BEEF);

        // Stray ctrl_done during ISSUE.
        send(1'b0, 32'h0000_0100, 32'h0, 4, 32'h1111_2222);
        @(negedge clk);
        stray_done = 1'b1;
        chk("stray_issue_cmd", 32'(cmd_rd), 32'd1);
        @(negedge clk);
        stray_done = 1'b0;
        chk("stray_issue_cmd_hold", 32'(cmd_rd), 32'd1);
        chk("stray_issue_no_done", 32'(cpu_done), 32'd0);
        drain();

        // Three back-to-back writes against a slow controller.
        send(1'b1, 32'h0000_0100, 32'hA5A5_0001, 5, 32'h7777_7777);
        send(1'b1, 32'h0000_0104, 32'hA5A5_0002, 5, 32'h7777_7777);
        send(1'b1, 32'h0000_0108, 32'hA5A5_0003, 5, 32'h7777_7777);
        chk("b2b_ready_low", 32'(cpu_ready), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        drain();
        chk("wr_rdata_zero", cpu_rdata, 32'h0);

        // Illegal request: both rd and wr.
        cpu_rd   = 1'b1;
        cpu_wr   = 1'b1;
        cpu_addr = 32'hFFFF_FFFC;
        @(negedge clk);
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        chk("illegal_pulse", 32'(err_illegal), 32'd1);
        chk("illegal_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("illegal_clear", 32'(err_illegal), 32'd0);
        chk("illegal_busy2", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("illegal_busy3", 32'(busy), 32'd0);

        // Timeout on the first read, the queued read still completes.
        send(1'b0, 32'h0000_0200, 32'h0, -1, 32'h0);
        send(1'b0, 32'h0000_0204, 32'h0, 2, 32'hCAFE_F00D);
        drain();
        chk("to_next_rdata", cpu_rdata, 32'hCAFE_F00D);

        // Reset while in WAIT with one more request queued.
        send(1'b0, 32'h0000_0300, 32'h0, -1, 32'h0);
        send(1'b0, 32'h0000_0304, 32'h0, -1, 32'h0);
        repeat (2) @(negedge clk);
        chk("rstw_in_wait", 32'(cmd_rd), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        ctrl_q.delete();
        #1;
        chk("rstw_cmd", 32'({cmd_rd, cmd_wr}), 32'd0);
        chk("rstw_address", address, 32'h0);
        chk("rstw_ready", 32'(cpu_ready), 32'd1);
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_done", 32'(cpu_done), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("rstw_busy_after", 32'(busy), 32'd0);
        chk("rstw_cmd_after", 32'({cmd_rd, cmd_wr}), 32'd0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
